// File: rtl/fp_normalize_pipe_pkg.sv
// Shared widths and helpers for the pipelined FP normalize block.
package fp_normalize_pipe_pkg;

   localparam int WEXP_DEF = 8;
   localparam int WSIG_DEF = 23;

   function automatic int sum_width(input int wsig);
      return wsig + 3;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/fp_normalize_pipe_lzc.sv
// Leading-zero counter; an all-zero input reports W-1.
module fp_lzc #(
   parameter int W  = 26,
   parameter int SH = 5
) (
   input  logic [W-1:0]  din,
   output logic [SH-1:0] lz
);

   // Highest set bit is seen last, so it decides the count.
   always_comb begin
      lz = SH'(W - 1);
      for (int i = 0; i < W; i++) begin
         if (din[i]) lz = SH'(W - 1 - i);
      end
   end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage normalize between significand adder and rounder.
// Stage A counts leading zeros, stage B shifts and forms the flags.
module fp_normalize_pipe
   import fp_normalize_pipe_pkg::*;
#(
   parameter int  WEXP = WEXP_DEF,
   parameter int  WSIG = WSIG_DEF,
   localparam int SW   = sum_width(WSIG),
   localparam int SH   = clog2(SW)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SW-1:0]   in_sum,
   input  logic [WEXP-1:0] in_bigexp,
   input  logic            in_presticky,
   input  logic            in_guard,
   input  logic            in_effop,
   input  logic            in_undertrap,
   input  logic            in_ftz,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [WSIG-1:0] out_normsum,
   output logic [SH-1:0]   out_shift,
   output logic [WEXP:0]   out_overexp,
   output logic            out_round,
   output logic            out_sticky,
   output logic            out_zero,
   output logic            out_denorm,
   output logic            out_inex
);

   localparam int WE1 = WEXP + 1;
   localparam int SAW = (WEXP > SH) ? WEXP : SH;

   typedef struct packed {
      logic [SW-1:0]   sum;
      logic [WEXP-1:0] bigexp;
      logic [WEXP:0]   overexp;
      logic [SH-1:0]   lz;
      logic            presticky;
      logic            guard;
      logic            effop;
      logic            undertrap;
      logic            ftz;
   } stage_a_t;

   stage_a_t        a_d, a_q;
   logic            va;
   logic            rdya, rdyb;
   logic [SH-1:0]   lz;

   assign rdyb     = ~out_valid | out_ready;
   assign rdya     = ~va | rdyb;
   assign in_ready = rdya;

   fp_lzc #(.W(SW), .SH(SH)) u_lzc (
      .din (in_sum),
      .lz  (lz)
   );

   always_comb begin
      a_d.sum       = in_sum;
      a_d.bigexp    = in_bigexp;
      a_d.overexp   = {1'b0, in_bigexp} - WE1'(lz);
      a_d.lz        = lz;
      a_d.presticky = in_presticky;
      a_d.guard     = in_guard;
      a_d.effop     = in_effop;
      a_d.undertrap = in_undertrap;
      a_d.ftz       = in_ftz;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         va  <= 1'b0;
         a_q <= '0;
      end else if (in_valid && rdya) begin
         va  <= 1'b1;
         a_q <= a_d;
      end else if (rdyb) begin
         va  <= 1'b0;
      end
   end

   logic            uf, two;
   logic [SAW-1:0]  shamt;
   logic [SW-1:0]   shifted;
   logic [WSIG-1:0] nsum;
   logic            rnd, stk, zro, dnm, inx;

   always_comb begin
      uf      = a_q.overexp[WEXP];
      // Underflow without trap stops at the denormal boundary.
      shamt   = (uf && !a_q.undertrap) ? SAW'(a_q.bigexp)
                                       : SAW'(a_q.lz);
      shifted = a_q.sum << shamt;
      nsum    = shifted[SW-2:2];
      two     = a_q.effop && (a_q.lz == SH'(2));
      if (two) begin
         rnd = a_q.presticky ^ a_q.guard;
         stk = a_q.presticky;
      end else begin
         rnd = ~((a_q.lz >= SH'(2)) & a_q.effop) & shifted[1];
         stk = shifted[0] | a_q.guard | a_q.presticky;
      end
      zro = (shifted == '0);
      dnm = uf & (|nsum);
      inx = rnd | stk;
      if (a_q.ftz && dnm) begin
         nsum = '0;
         zro  = 1'b1;
         dnm  = 1'b0;
         inx  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_normsum <= '0;
         out_shift   <= '0;
         out_overexp <= '0;
         out_round   <= 1'b0;
         out_sticky  <= 1'b0;
         out_zero    <= 1'b0;
         out_denorm  <= 1'b0;
         out_inex    <= 1'b0;
      end else if (rdyb) begin
         out_valid <= va;
         if (va) begin
            out_normsum <= nsum;
            out_shift   <= a_q.lz;
            out_overexp <= a_q.overexp;
            out_round   <= rnd;
            out_sticky  <= stk;
            out_zero    <= zro;
            out_denorm  <= dnm;
            out_inex    <= inx;
         end
      end
   end

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Self-checking bench for fp_normalize_pipe at default widths.
module tb_fp_normalize_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, in_valid, in_ready;
   logic [25:0] in_sum;
   logic [7:0]  in_bigexp;
   logic        in_presticky, in_guard, in_effop, in_undertrap, in_ftz;
   logic        out_valid, out_ready;
   logic [22:0] out_normsum;
   logic [4:0]  out_shift;
   logic [8:0]  out_overexp;
   logic        out_round, out_sticky, out_zero, out_denorm, out_inex;

   int n_checks = 0;
   int n_fail   = 0;

   fp_normalize_pipe dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sum       (in_sum),
      .in_bigexp    (in_bigexp),
      .in_presticky (in_presticky),
      .in_guard     (in_guard),
      .in_effop     (in_effop),
      .in_undertrap (in_undertrap),
      .in_ftz       (in_ftz),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_normsum  (out_normsum),
      .out_shift    (out_shift),
      .out_overexp  (out_overexp),
      .out_round    (out_round),
      .out_sticky   (out_sticky),
      .out_zero     (out_zero),
      .out_denorm   (out_denorm),
      .out_inex     (out_inex)
   );

   typedef struct packed {
      logic [25:0] sum;
      logic [7:0]  bigexp;
      logic        ps, g, eo, ut, ftz;
   } beat_t;

   typedef struct packed {
      logic [22:0] ns;
      logic [4:0]  sh;
      logic [8:0]  oe;
      logic        r, s, z, d, i;
   } res_t;

   function automatic res_t model(beat_t b);
      res_t        o;
      int          lz, oe, amt;
      bit          uf, two;
      logic [25:0] sh;
      lz = 0;
      while (lz < 25 && !b.sum[25-lz]) lz++;
      oe  = (int'(b.bigexp) - lz + 512) % 512;
      uf  = (oe >= 256);
      amt = (uf && !b.ut) ? int'(b.bigexp) : lz;
      sh  = (amt > 25) ? 26'd0 : 26'(longint'(b.sum) << amt);
      two = b.eo && (lz == 2);
      o.sh = 5'(lz);
      o.oe = 9'(oe);
      o.ns = sh[24:2];
      o.r  = two ? (b.ps ^ b.g) : (!(lz >= 2 && b.eo) && sh[1]);
      o.s  = two ? b.ps : (sh[0] | b.g | b.ps);
      o.z  = (sh == 26'd0);
      o.d  = uf && (o.ns != 23'd0);
      o.i  = o.r | o.s;
      if (b.ftz && o.d) begin
         o.ns = 23'd0;
         o.z  = 1'b1;
         o.d  = 1'b0;
         o.i  = 1'b1;
      end
      return o;
   endfunction

   function automatic res_t got_now();
      res_t r;
      r = {out_normsum, out_shift, out_overexp, out_round,
           out_sticky, out_zero, out_denorm, out_inex};
      return r;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      b.sum    = 26'($urandom) >> $urandom_range(0, 26);
      b.bigexp = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30))
                                             : 8'($urandom);
      b.ps     = 1'($urandom);
      b.g      = 1'($urandom);
      b.eo     = 1'($urandom);
      b.ut     = 1'($urandom);
      b.ftz    = 1'($urandom);
      return b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(beat_t b);
      in_sum       = b.sum;
      in_bigexp    = b.bigexp;
      in_presticky = b.ps;
      in_guard     = b.g;
      in_effop     = b.eo;
      in_undertrap = b.ut;
      in_ftz       = b.ftz;
   endtask

   task automatic run_one(input beat_t b, output res_t got, output int lat);
      put(b);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      got = got_now();
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      put('0);
      step();
      step();
      reset = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hs: valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
      n_checks++;
      if (got_now() !== res_t'(0)) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 0", got_now());
      end
   endtask

   task automatic test_directed();
      beat_t b[5];
      res_t  e[5];
      res_t  got;
      int    lat;
      b[0] = '{sum:26'h2000000, bigexp:8'd100, ps:1'b0, g:1'b1, eo:1'b0, ut:1'b0, ftz:1'b0};
      e[0] = '{ns:23'd0, sh:5'd0, oe:9'd100, r:1'b0, s:1'b1, z:1'b0, d:1'b0, i:1'b1};
      b[1] = '{sum:26'h0800000, bigexp:8'd50, ps:1'b0, g:1'b1, eo:1'b1, ut:1'b0, ftz:1'b0};
      e[1] = '{ns:23'd0, sh:5'd2, oe:9'd48, r:1'b1, s:1'b0, z:1'b0, d:1'b0, i:1'b1};
      b[2] = '{sum:26'h0000004, bigexp:8'd10, ps:1'b0, g:1'b0, eo:1'b0, ut:1'b0, ftz:1'b0};
      e[2] = '{ns:23'h000400, sh:5'd23, oe:9'h1F3, r:1'b0, s:1'b0, z:1'b0, d:1'b1, i:1'b0};
      b[3] = '{sum:26'h0000004, bigexp:8'd10, ps:1'b0, g:1'b0, eo:1'b0, ut:1'b0, ftz:1'b1};
      e[3] = '{ns:23'd0, sh:5'd23, oe:9'h1F3, r:1'b0, s:1'b0, z:1'b1, d:1'b0, i:1'b1};
      b[4] = '{sum:26'd0, bigexp:8'd5, ps:1'b0, g:1'b1, eo:1'b0, ut:1'b0, ftz:1'b0};
      e[4] = '{ns:23'd0, sh:5'd25, oe:9'h1EC, r:1'b0, s:1'b1, z:1'b1, d:1'b0, i:1'b1};
      for (int k = 0; k < 5; k++) begin
         run_one(b[k], got, lat);
         n_checks++;
         if (lat !== 2) begin
            n_fail++;
            $display("FAIL latency_%0d: got %0d want 2", k, lat);
         end
         n_checks++;
         if (got !== e[k]) begin
            n_fail++;
            $display("FAIL directed_%0d: got %h want %h", k, got, e[k]);
         end
      end
      step();
   endtask

   task automatic test_back_to_back();
      beat_t b1, b2;
      res_t  e1, e2;
      b1 = rand_beat();
      b2 = rand_beat();
      b2.sum = ~b1.sum;
      e1 = model(b1);
      e2 = model(b2);
      out_ready = 1'b0;
      put(b1);
      in_valid = 1'b1;
      step();
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready1: got %b want 1", in_ready);
      end
      put(b2);
      step();
      in_valid = 1'b0;
      #1;
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || got_now() !== e1) begin
            n_fail++;
            $display("FAIL b2b_hold_%0d: rdy=%b vld=%b got %h want 0/1/%h",
                     c, in_ready, out_valid, got_now(), e1);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || got_now() !== e2) begin
         n_fail++;
         $display("FAIL b2b_second: vld=%b got %h want 1/%h", out_valid, got_now(), e2);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_drain: vld=%b rdy=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_random();
      res_t  q[$];
      res_t  exp;
      beat_t b;
      int    k;
      for (int c = 0; c < 400; c++) begin
         b = rand_beat();
         put(b);
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL random_extra: got %h want none", got_now());
            end else begin
               exp = q.pop_front();
               if (got_now() !== exp) begin
                  n_fail++;
                  $display("FAIL random_beat: got %h want %h", got_now(), exp);
               end
            end
         end
         if (in_valid && in_ready) q.push_back(model(b));
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while (q.size() > 0 && k < 20) begin
         #1;
         if (out_valid) begin
            exp = q.pop_front();
            n_checks++;
            if (got_now() !== exp) begin
               n_fail++;
               $display("FAIL random_tail: got %h want %h", got_now(), exp);
            end
         end
         step();
         k++;
      end
      #1;
      n_checks++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL random_drain: left %0d vld=%b want 0/0", q.size(), out_valid);
      end
   endtask

   task automatic test_reset_inflight();
      bit stale;
      out_ready = 1'b0;
      put(rand_beat());
      in_valid = 1'b1;
      step();
      put(rand_beat());
      step();
      reset = 1'b1;
      put(rand_beat());
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || got_now() !== res_t'(0)) begin
         n_fail++;
         $display("FAIL rst_flight: vld=%b rdy=%b got %h want 0/1/0",
                  out_valid, in_ready, got_now());
      end
      out_ready = 1'b1;
      stale = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (out_valid) stale = 1'b1;
      end
      n_checks++;
      if (stale) begin
         n_fail++;
         $display("FAIL rst_stale: got stale beat want none");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/fp_normalize_pipe.md
# fp_normalize_pipe

Pipelined, parametrised successor to the FP adder's combinational normalize stage. Takes the un-normalized adder sum with its guard/sticky bits, left-shifts it so the leading 1 reaches the MSB, or so the result is denormal when the exponent would underflow, and produces the mantissa, round/sticky bits, adjusted exponent and status flags. It sits between the significand adder and the rounder. It adds a 2-stage valid/ready pipeline, generic exponent/significand widths, and an optional flush-to-zero mode.

## Interface
- WEXP, default 8: exponent width.
- WSIG, default 23: stored mantissa width; sum width SW = WSIG+3; shift width SH = clog2(SW).
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept this cycle.
- in_sum  in  SW  un-normalized sum.
- in_bigexp  in  WEXP  larger operand exponent.
- in_presticky, in_guard  in  1 each  sticky and guard from alignment.
- in_effop  in  1  effective subtraction.
- in_undertrap  in  1  underflow trap enabled.
- in_ftz  in  1  flush denormal results to zero.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_normsum  out  WSIG  normalized mantissa.
- out_shift  out  SH  leading-zero count.
- out_overexp  out  WEXP+1  in_bigexp − lz, two's complement; bit WEXP set means underflow.
- out_round, out_sticky, out_zero, out_denorm, out_inex  out  1 each  flags.

## Operation
- lz is the leading-zero count of in_sum. If in_sum == 0, lz = SW−1.
- overexp = {1'b0, bigexp} − lz, computed at WEXP+1 bits with wrap.
- uf = overexp[WEXP].
- shamt = (uf & ~undertrap) ? bigexp : lz.
- shifted = (sum << shamt), truncated to SW.
- normsum = shifted[SW−2:2].
- shifttwo = effop & (lz == 2).
- round = shifttwo ? (presticky ^ guard) : (~((lz ≥ 2) & effop) & shifted[1]).
- sticky = shifttwo ? presticky : (shifted[0] | guard | presticky).
- zero = (shifted == 0).
- denorm = uf & |normsum.
- inex = round | sticky.
- FTZ: if ftz & denorm, then normsum = 0, zero = 1, denorm = 0, inex = 1. round, sticky, overexp and shift are unchanged.
- If bigexp exceeds SW−1 while uf=1, the shift truncates and the result is zero. This is legal and needs no special case.

## Timing
- Stage A registers the beat fields plus lz and overexp.
- Stage B performs the shift and flag logic and registers all out_* signals.
- Latency is 2 cycles from an in_valid&in_ready edge to out_valid.
- Throughput is 1 beat per cycle when out_ready stays high.
- Ready chain, all combinational:
  - rdyB = ~out_valid | out_ready.
  - rdyA = ~vA | rdyB.
  - in_ready = rdyA.
- Stage A loads when in_valid & rdyA; otherwise vA clears when B takes the beat.
- While out_valid & ~out_ready, every out_* field holds stable.
- Beats are never dropped, duplicated or reordered.
- in_valid is not required to be held; in_ready has no dependence on in_valid.
- Reset:
  - vA = 0, out_valid = 0, all out_* data = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset during a transfer discards in-flight beats; it takes priority over a simultaneous load.

## Structure
- Shared constants include: WEXP/WSIG defaults, SW and SH derivation (clog2 function).
- Sub-module fp_lzc: parametrised leading-zero counter (width SW, output SH, zero-input → SW−1). Purely combinational, instantiated in stage A.
- Top module contains the pipeline registers, handshake logic, shifter and flag logic.

## Test plan
Defaults: WEXP=8, WSIG=23, SW=26.
- sum=26'h2000000, bigexp=100, guard=1, effop=0 -> shift=0, overexp=100, normsum=0, round=0, sticky=1, inex=1, out_valid exactly 2 cycles after acceptance.
- effop=1, sum=26'h0800000, bigexp=50, guard=1, presticky=0 -> shift=2, overexp=48, round=1, sticky=0, normsum=0.
- sum=26'h0000004, bigexp=10, undertrap=0, ftz=0 -> overexp=9'h1F3, normsum=23'h000400, denorm=1. Same beat with ftz=1 -> normsum=0, zero=1, denorm=0, inex=1.
- sum=0, bigexp=5 -> shift=25, zero=1, denorm=0, inex equals guard|presticky.
- Back-to-back beats with out_ready=0 -> in_ready drops after 2 accepted, outputs frozen on beat 1. Raising out_ready drains both beats in order, one per cycle, and in_ready returns to 1.
- Assert reset with 2 beats in flight -> next cycle out_valid=0, outputs=0, in_ready=1; no stale beat appears afterwards.
